// File: rtl/ft232h_pkg.sv
// ft232h_pkg: shared widths and error-bit indices for the FT232H sync-245 responder
package ft232h_pkg;
    localparam int FT_BYTE_W      = 8;
    localparam int ERR_W          = 3;
    localparam int ERR_UNDERRUN   = 0;
    localparam int ERR_OVERRUN    = 1;
    localparam int ERR_CONTENTION = 2;
endpackage

// File: rtl/ft232h_sync_fifo.sv
// ft232h_sync_fifo: single-clock show-ahead FIFO with level output
module ft232h_sync_fifo
    import ft232h_pkg::*;
#(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned WIDTH = FT_BYTE_W
) (
    input  logic                    usb_clk_i,
    input  logic                    nrst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;

    always_ff @(posedge usb_clk_i)
        if (push) mem[wr_ptr] <= wdata;

    always_ff @(posedge usb_clk_i or negedge nrst)
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
        end

    assign rdata = mem[rd_ptr];
    assign full  = level == (AW+1)'(DEPTH);
    assign empty = level == '0;
endmodule

// File: rtl/ft232h_sync245_responder.sv
// ft232h_sync245_responder: device side of the FT232H sync-245 FIFO bus with stall injection
module ft232h_sync245_responder
    import ft232h_pkg::*;
#(
    parameter int unsigned RX_DEPTH     = 512,
    parameter int unsigned TX_DEPTH     = 512,
    parameter int unsigned STALL_PERIOD = 512,
    parameter int unsigned STALL_CYCLES = 4
) (
    input  logic                 usb_clk_i,
    input  logic                 nrst,
    output logic                 usb_rxf_n_o,
    output logic                 usb_txe_n_o,
    input  logic                 usb_rd_n_i,
    input  logic                 usb_wr_n_i,
    input  logic                 usb_oe_n_i,
    input  logic [FT_BYTE_W-1:0] usb_data_i,
    output logic [FT_BYTE_W-1:0] usb_data_o,
    output logic                 usb_data_oe_o,
    input  logic [FT_BYTE_W-1:0] host_tx_data_i,
    input  logic                 host_tx_valid_i,
    output logic                 host_tx_ready_o,
    output logic [FT_BYTE_W-1:0] host_rx_data_o,
    output logic                 host_rx_valid_o,
    input  logic                 host_rx_ready_i,
    input  logic                 err_clr_i,
    output logic [ERR_W-1:0]     err_o,
    output logic [31:0]          rx_count_o,
    output logic [31:0]          tx_count_o
);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TAW = $clog2(TX_DEPTH);

    logic                 rx_push, rx_pop, rx_full, rx_empty;
    logic                 tx_push, tx_pop, tx_full, tx_empty;
    logic [RAW:0]         rx_level, rx_lvl_nxt;
    logic [TAW:0]         tx_level, tx_lvl_nxt;
    logic [FT_BYTE_W-1:0] rx_head, last_q;
    logic [31:0]          stall_cnt, stall_left, stall_cnt_nxt, stall_left_nxt;
    logic                 stall_hit;
    logic [ERR_W-1:0]     err_set;

    ft232h_sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(FT_BYTE_W)) u_rx (
        .usb_clk_i(usb_clk_i), .nrst(nrst), .push(rx_push), .pop(rx_pop),
        .wdata(host_tx_data_i), .rdata(rx_head), .level(rx_level),
        .full(rx_full), .empty(rx_empty)
    );

    ft232h_sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(FT_BYTE_W)) u_tx (
        .usb_clk_i(usb_clk_i), .nrst(nrst), .push(tx_push), .pop(tx_pop),
        .wdata(usb_data_i), .rdata(host_rx_data_o), .level(tx_level),
        .full(tx_full), .empty(tx_empty)
    );

    always_comb begin
        rx_push    = host_tx_valid_i & ~rx_full;
        rx_pop     = ~usb_oe_n_i & ~usb_rd_n_i & ~rx_empty;
        tx_push    = ~usb_wr_n_i & ~usb_txe_n_o & usb_oe_n_i;
        tx_pop     = host_rx_ready_i & ~tx_empty;
        rx_lvl_nxt = rx_level + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
        tx_lvl_nxt = tx_level + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
        stall_hit  = STALL_PERIOD != 0 && tx_push && stall_cnt == STALL_PERIOD - 1;
        stall_cnt_nxt  = stall_hit ? '0 : (tx_push && STALL_PERIOD != 0) ? stall_cnt + 1 : stall_cnt;
        stall_left_nxt = stall_hit ? STALL_CYCLES : stall_left != 0 ? stall_left - 1 : '0;
        err_set                 = '0;
        err_set[ERR_UNDERRUN]   = ~usb_oe_n_i & ~usb_rd_n_i & rx_empty;
        err_set[ERR_OVERRUN]    = ~usb_wr_n_i & usb_txe_n_o;
        err_set[ERR_CONTENTION] = ~usb_wr_n_i & ~usb_oe_n_i;
    end

    // Bus-facing flags are registered against the post-edge queue state.
    always_ff @(posedge usb_clk_i or negedge nrst)
        if (!nrst) begin
            usb_rxf_n_o   <= 1'b1;
            usb_txe_n_o   <= 1'b1;
            usb_data_oe_o <= 1'b0;
            last_q        <= '0;
            err_o         <= '0;
        end else begin
            usb_rxf_n_o   <= rx_lvl_nxt == '0;
            usb_txe_n_o   <= tx_lvl_nxt == (TAW+1)'(TX_DEPTH) || stall_left_nxt != 0;
            usb_data_oe_o <= ~usb_oe_n_i;
            if (rx_pop) last_q <= rx_head;
            err_o         <= err_clr_i ? '0 : err_o | err_set;
        end

    always_ff @(posedge usb_clk_i or negedge nrst)
        if (!nrst) begin
            rx_count_o <= '0;
            tx_count_o <= '0;
            stall_cnt  <= '0;
            stall_left <= '0;
        end else begin
            rx_count_o <= rx_count_o + 32'(rx_pop);
            tx_count_o <= tx_count_o + 32'(tx_push);
            stall_cnt  <= stall_cnt_nxt;
            stall_left <= stall_left_nxt;
        end

    // An empty RX queue keeps the last delivered byte on the bus.
    assign usb_data_o      = rx_empty ? last_q : rx_head;
    assign host_tx_ready_o = ~rx_full;
    assign host_rx_valid_o = ~tx_empty;
endmodule

// File: tb/tb_ft232h_sync245_responder.sv
// tb_ft232h_sync245_responder: directed stimulus checked against a queue-based bus model
module tb_ft232h_sync245_responder;
    localparam int RXD = 512;
    localparam int TXD = 8;
    localparam int SP  = 512;
    localparam int SC  = 4;

    logic        usb_clk_i = 0;
    logic        nrst = 0;
    logic        usb_rxf_n_o, usb_txe_n_o, usb_data_oe_o;
    logic        usb_rd_n_i = 1, usb_wr_n_i = 1, usb_oe_n_i = 1;
    logic [7:0]  usb_data_i = 0, usb_data_o;
    logic [7:0]  host_tx_data_i = 0, host_rx_data_o;
    logic        host_tx_valid_i = 0, host_tx_ready_o, host_rx_valid_o, host_rx_ready_i = 0;
    logic        err_clr_i = 0;
    logic [2:0]  err_o;
    logic [31:0] rx_count_o, tx_count_o;

    always #5 usb_clk_i = ~usb_clk_i;

    ft232h_sync245_responder #(
        .RX_DEPTH(RXD), .TX_DEPTH(TXD), .STALL_PERIOD(SP), .STALL_CYCLES(SC)
    ) dut (
        .usb_clk_i(usb_clk_i), .nrst(nrst),
        .usb_rxf_n_o(usb_rxf_n_o), .usb_txe_n_o(usb_txe_n_o),
        .usb_rd_n_i(usb_rd_n_i), .usb_wr_n_i(usb_wr_n_i), .usb_oe_n_i(usb_oe_n_i),
        .usb_data_i(usb_data_i), .usb_data_o(usb_data_o), .usb_data_oe_o(usb_data_oe_o),
        .host_tx_data_i(host_tx_data_i), .host_tx_valid_i(host_tx_valid_i),
        .host_tx_ready_o(host_tx_ready_o), .host_rx_data_o(host_rx_data_o),
        .host_rx_valid_o(host_rx_valid_o), .host_rx_ready_i(host_rx_ready_i),
        .err_clr_i(err_clr_i), .err_o(err_o),
        .rx_count_o(rx_count_o), .tx_count_o(tx_count_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: two byte queues, counters, sticky errors and a stall timer.
    logic [7:0]  rx_q[$], tx_q[$], got_q[$];
    logic [7:0]  m_last = 0;
    logic        m_oe = 0, m_txe = 1;
    logic [2:0]  m_err = 0;
    logic [31:0] m_rxc = 0, m_txc = 0;
    int          m_total = 0, m_stall = 0;

    initial forever begin
        logic rdreq, und, ovr, cont, acc, hpush;
        @(posedge usb_clk_i or negedge nrst);
        if (!nrst) begin
            rx_q.delete(); tx_q.delete();
            m_last = 0; m_oe = 0; m_txe = 1; m_err = 0;
            m_rxc = 0; m_txc = 0; m_total = 0; m_stall = 0;
        end else begin
            rdreq = !usb_oe_n_i && !usb_rd_n_i;
            und   = rdreq && rx_q.size() == 0;
            ovr   = !usb_wr_n_i && m_txe;
            cont  = !usb_wr_n_i && !usb_oe_n_i;
            acc   = !usb_wr_n_i && !m_txe && usb_oe_n_i;
            hpush = host_tx_valid_i && rx_q.size() < RXD;
            if (rdreq && rx_q.size() > 0) begin
                m_last = rx_q.pop_front();
                m_rxc++;
            end
            if (host_rx_ready_i && tx_q.size() > 0) void'(tx_q.pop_front());
            if (hpush) rx_q.push_back(host_tx_data_i);
            if (acc) begin
                tx_q.push_back(usb_data_i);
                m_txc++;
                m_total++;
            end
            if (acc && m_total % SP == 0) m_stall = SC;
            else if (m_stall > 0) m_stall--;
            m_txe = tx_q.size() == TXD || m_stall > 0;
            m_oe  = !usb_oe_n_i;
            m_err = err_clr_i ? 3'b000 : m_err | {cont, ovr, und};
        end
    end

    initial forever begin
        @(negedge usb_clk_i);
        if (nrst) begin
            chk("rxf_n", 32'(usb_rxf_n_o), 32'(rx_q.size() == 0));
            chk("txe_n", 32'(usb_txe_n_o), 32'(m_txe));
            chk("data_oe", 32'(usb_data_oe_o), 32'(m_oe));
            chk("data_o", 32'(usb_data_o), 32'(rx_q.size() > 0 ? rx_q[0] : m_last));
            chk("host_tx_ready", 32'(host_tx_ready_o), 32'(rx_q.size() < RXD));
            chk("host_rx_valid", 32'(host_rx_valid_o), 32'(tx_q.size() > 0));
            if (tx_q.size() > 0) chk("host_rx_data", 32'(host_rx_data_o), 32'(tx_q[0]));
            chk("err", 32'(err_o), 32'(m_err));
            chk("rx_count", rx_count_o, m_rxc);
            chk("tx_count", tx_count_o, m_txc);
            if (host_rx_valid_o && host_rx_ready_i) got_q.push_back(host_rx_data_o);
        end
    end

    task automatic step();
        @(posedge usb_clk_i);
        #2;
    endtask

    initial begin
        int hi, bad;
        logic [7:0] exp_rd [3];
        exp_rd[0] = 8'h11; exp_rd[1] = 8'h22; exp_rd[2] = 8'h33;
        #13;
        chk("rst_rxf_n", 32'(usb_rxf_n_o), 32'd1);
        chk("rst_txe_n", 32'(usb_txe_n_o), 32'd1);
        chk("rst_data_oe", 32'(usb_data_oe_o), 32'd0);
        chk("rst_data_o", 32'(usb_data_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_counts", rx_count_o | tx_count_o, 32'd0);
        step();
        nrst = 1;
        step();

        // 1: host pushes three bytes, FPGA reads them back
        host_tx_valid_i = 1;
        for (int i = 0; i < 3; i++) begin
            host_tx_data_i = exp_rd[i];
            step();
        end
        host_tx_valid_i = 0;
        chk("t1_head", 32'(usb_data_o), 32'h11);
        chk("t1_rxf_low", 32'(usb_rxf_n_o), 32'd0);
        usb_oe_n_i = 0;
        step();
        chk("t1_oe_latency", 32'(usb_data_oe_o), 32'd1);
        usb_rd_n_i = 0;
        for (int i = 0; i < 3; i++) begin
            chk("t1_rd_byte", 32'(usb_data_o), 32'(exp_rd[i]));
            step();
            chk("t1_rxf", 32'(usb_rxf_n_o), 32'(i == 2));
        end
        usb_rd_n_i = 1;
        usb_oe_n_i = 1;
        step();
        chk("t1_rx_count", rx_count_o, 32'd3);
        chk("t1_err", 32'(err_o), 32'd0);

        // 2: underrun
        usb_oe_n_i = 0;
        usb_rd_n_i = 0;
        step();
        usb_oe_n_i = 1;
        usb_rd_n_i = 1;
        chk("t2_err", 32'(err_o), 32'b001);
        chk("t2_data_hold", 32'(usb_data_o), 32'h33);
        chk("t2_rx_count", rx_count_o, 32'd3);
        err_clr_i = 1;
        step();
        err_clr_i = 0;
        chk("t2_clr", 32'(err_o), 32'd0);

        // 3: 512 streamed writes followed by an injected stall
        host_rx_ready_i = 1;
        usb_wr_n_i = 0;
        for (int i = 0; i < 512; i++) begin
            usb_data_i = 8'(i);
            step();
        end
        usb_wr_n_i = 1;
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            hi += int'(usb_txe_n_o);
            step();
        end
        chk("t3_stall_len", 32'(hi), 32'd4);
        chk("t3_tx_count", tx_count_o, 32'd512);
        chk("t3_err", 32'(err_o), 32'd0);
        chk("t3_got_size", 32'(got_q.size()), 32'd512);
        bad = 0;
        foreach (got_q[i]) if (got_q[i] != 8'(i)) bad++;
        chk("t3_order", 32'(bad), 32'd0);
        host_rx_ready_i = 0;
        step();

        // 4: fill the 8-deep TX queue, then overrun it
        usb_wr_n_i = 0;
        for (int i = 0; i < 9; i++) begin
            usb_data_i = 8'hA0 + 8'(i);
            if (i == 8) chk("t4_txe_full", 32'(usb_txe_n_o), 32'd1);
            step();
        end
        usb_wr_n_i = 1;
        chk("t4_err", 32'(err_o), 32'b010);
        chk("t4_tx_count", tx_count_o, 32'd520);
        chk("t4_head", 32'(host_rx_data_o), 32'hA0);
        err_clr_i = 1;
        step();
        err_clr_i = 0;
        host_rx_ready_i = 1;
        repeat (9) step();
        host_rx_ready_i = 0;
        chk("t4_drained", 32'(host_rx_valid_o), 32'd0);
        chk("t4_txe_open", 32'(usb_txe_n_o), 32'd0);

        // 5: bus contention
        usb_wr_n_i = 0;
        usb_oe_n_i = 0;
        step();
        usb_wr_n_i = 1;
        usb_oe_n_i = 1;
        chk("t5_err", 32'(err_o), 32'b100);
        chk("t5_tx_count", tx_count_o, 32'd520);
        chk("t5_nothing_queued", 32'(host_rx_valid_o), 32'd0);
        usb_wr_n_i = 0;
        usb_oe_n_i = 0;
        err_clr_i = 1;
        step();
        usb_wr_n_i = 1;
        usb_oe_n_i = 1;
        err_clr_i = 0;
        chk("t5_clr_wins", 32'(err_o), 32'd0);

        // 6: asynchronous reset in the middle of a read
        host_tx_valid_i = 1;
        for (int i = 0; i < 5; i++) begin
            host_tx_data_i = 8'h51 + 8'(i);
            step();
        end
        host_tx_valid_i = 0;
        usb_oe_n_i = 0;
        step();
        usb_rd_n_i = 0;
        step();
        chk("t6_mid_read", 32'(usb_data_o), 32'h52);
        chk("t6_rx_count", rx_count_o, 32'd4);
        #1 nrst = 0;
        #1;
        chk("t6_rxf_n", 32'(usb_rxf_n_o), 32'd1);
        chk("t6_data_oe", 32'(usb_data_oe_o), 32'd0);
        chk("t6_txe_n", 32'(usb_txe_n_o), 32'd1);
        chk("t6_counts", rx_count_o | tx_count_o, 32'd0);
        chk("t6_data_o", 32'(usb_data_o), 32'd0);
        usb_rd_n_i = 1;
        usb_oe_n_i = 1;
        step();
        step();
        nrst = 1;
        step();
        chk("t6_after_rxf", 32'(usb_rxf_n_o), 32'd1);
        chk("t6_after_txe", 32'(usb_txe_n_o), 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
